// File: rtl/dac_pkg.sv
// Shared state encoding and default widths/codes for the DAC bus sequencer.
package dac_pkg;

  localparam int CODE_W       = 8;
  localparam int DEFAULT_CODE = 178;

  typedef enum logic [1:0] {
    ST_WAKE  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_SLEEP = 2'd3
  } dac_state_t;

endpackage

// File: rtl/dac_sweep_gen.sv
// Step/hold counter for DAC sweeps: holds each code for 'hold' cycles and
// reports the next code to emit or that the sweep has run past its upper bound.
module dac_sweep_gen #(
  parameter int CODE_W = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] lo,
  input  logic [CODE_W-1:0] hi,
  input  logic [CODE_W-1:0] step,
  input  logic [HOLD_W-1:0] hold,
  input  logic              start,
  input  logic              abort,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              last
);

  logic [CODE_W-1:0] cur;
  logic [CODE_W-1:0] hi_r;
  logic [CODE_W-1:0] step_r;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_cnt;
  logic              active;
  logic [CODE_W:0]   next_sum;
  logic              hold_end;
  logic              beyond;

  // One extra bit so that running off the top of the code range counts as past hi.
  assign next_sum   = {1'b0, cur} + {1'b0, step_r};
  assign hold_end   = active && (hold_cnt == hold_r - HOLD_W'(1));
  assign beyond     = next_sum > {1'b0, hi_r};
  assign code       = next_sum[CODE_W-1:0];
  assign code_valid = hold_end && !beyond;
  assign last       = hold_end && beyond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= '0;
      hi_r     <= '0;
      step_r   <= '0;
      hold_r   <= '0;
      hold_cnt <= '0;
      active   <= 1'b0;
    end else if (start) begin
      cur      <= lo;
      hi_r     <= hi;
      step_r   <= (step == '0) ? CODE_W'(1) : step;
      hold_r   <= (hold == '0) ? HOLD_W'(1) : hold;
      hold_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (abort || last) begin
        active <= 1'b0;
      end else if (code_valid) begin
        cur      <= code;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/dac_seq_ctrl.sv
// DAC data bus sequencer: power sequencing (wake/sleep), arbitration between
// single-shot level writes and stepped sweeps, and the registered DAC code.
module dac_seq_ctrl #(
  parameter int CODE_W       = dac_pkg::CODE_W,
  parameter int DEFAULT_CODE = dac_pkg::DEFAULT_CODE,
  parameter int WAKE_CYCLES  = 100,
  parameter int HOLD_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lvl_req,
  input  logic [CODE_W-1:0] lvl_code,
  output logic              lvl_ack,
  input  logic              swp_start,
  input  logic [CODE_W-1:0] swp_lo,
  input  logic [CODE_W-1:0] swp_hi,
  input  logic [CODE_W-1:0] swp_step,
  input  logic [HOLD_W-1:0] swp_hold,
  input  logic              swp_abort,
  output logic              swp_busy,
  output logic              swp_done,
  input  logic              sleep_req,
  output logic [CODE_W-1:0] dac_code,
  output logic              dac_sleep,
  output logic              dac_ready
);

  import dac_pkg::*;

  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  dac_state_t        state;
  dac_state_t        next_state;
  logic [WAKE_W-1:0] wake_cnt;
  logic [WAKE_W-1:0] wake_cnt_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              ack_nxt;
  logic              done_nxt;
  logic              gen_start;
  logic              gen_abort;
  logic [CODE_W-1:0] gen_code;
  logic              gen_valid;
  logic              gen_last;

  dac_sweep_gen #(
    .CODE_W (CODE_W),
    .HOLD_W (HOLD_W)
  ) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .lo         (swp_lo),
    .hi         (swp_hi),
    .step       (swp_step),
    .hold       (swp_hold),
    .start      (gen_start),
    .abort      (gen_abort),
    .code       (gen_code),
    .code_valid (gen_valid),
    .last       (gen_last)
  );

  always_comb begin
    next_state   = state;
    wake_cnt_nxt = wake_cnt;
    code_nxt     = dac_code;
    ack_nxt      = 1'b0;
    done_nxt     = 1'b0;
    gen_start    = 1'b0;
    gen_abort    = 1'b0;
    unique case (state)
      ST_WAKE: begin
        if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) begin
          next_state   = ST_IDLE;
          wake_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt + WAKE_W'(1);
        end
      end
      // A request still high in its own ack cycle is the tail of the last write.
      ST_IDLE: begin
        if (swp_start) begin
          gen_start  = 1'b1;
          code_nxt   = swp_lo;
          next_state = ST_SWEEP;
        end else if (lvl_req && !lvl_ack) begin
          code_nxt = lvl_code;
          ack_nxt  = 1'b1;
        end else if (sleep_req) begin
          next_state = ST_SLEEP;
        end
      end
      ST_SWEEP: begin
        if (swp_abort) begin
          gen_abort  = 1'b1;
          next_state = ST_IDLE;
        end else if (gen_last) begin
          done_nxt   = 1'b1;
          next_state = ST_IDLE;
        end else if (gen_valid) begin
          code_nxt = gen_code;
        end
      end
      ST_SLEEP: begin
        if (!sleep_req) begin
          next_state   = ST_WAKE;
          wake_cnt_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WAKE;
      wake_cnt <= '0;
      dac_code <= CODE_W'(DEFAULT_CODE);
      lvl_ack  <= 1'b0;
      swp_done <= 1'b0;
    end else begin
      state    <= next_state;
      wake_cnt <= wake_cnt_nxt;
      dac_code <= code_nxt;
      lvl_ack  <= ack_nxt;
      swp_done <= done_nxt;
    end
  end

  assign swp_busy  = (state == ST_SWEEP);
  assign dac_sleep = (state == ST_SLEEP);
  assign dac_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Randomized bench for dac_seq_ctrl against an expected-trace model built from
// sweep code lists, level-request ack rules and wake/sleep timing.
module tb_dac_seq_ctrl;

  localparam int CODE_W  = 8;
  localparam int HOLD_W  = 16;
  localparam int WAKE    = 100;
  localparam int DEFCODE = 178;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lvl_req = 1'b0;
  logic [CODE_W-1:0] lvl_code = '0;
  logic              lvl_ack;
  logic              swp_start = 1'b0;
  logic [CODE_W-1:0] swp_lo = '0;
  logic [CODE_W-1:0] swp_hi = '0;
  logic [CODE_W-1:0] swp_step = '0;
  logic [HOLD_W-1:0] swp_hold = '0;
  logic              swp_abort = 1'b0;
  logic              swp_busy;
  logic              swp_done;
  logic              sleep_req = 1'b0;
  logic [CODE_W-1:0] dac_code;
  logic              dac_sleep;
  logic              dac_ready;

  int n_checks = 0;
  int n_fails  = 0;
  int model_code = DEFCODE;

  always #5 clk = ~clk;

  dac_seq_ctrl #(
    .CODE_W       (CODE_W),
    .DEFAULT_CODE (DEFCODE),
    .WAKE_CYCLES  (WAKE),
    .HOLD_W       (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lvl_req   (lvl_req),
    .lvl_code  (lvl_code),
    .lvl_ack   (lvl_ack),
    .swp_start (swp_start),
    .swp_lo    (swp_lo),
    .swp_hi    (swp_hi),
    .swp_step  (swp_step),
    .swp_hold  (swp_hold),
    .swp_abort (swp_abort),
    .swp_busy  (swp_busy),
    .swp_done  (swp_done),
    .sleep_req (sleep_req),
    .dac_code  (dac_code),
    .dac_sleep (dac_sleep),
    .dac_ready (dac_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(output int cycles, output int acks);
    cycles = 0;
    acks   = 0;
    while (!dac_ready && cycles < 300) begin
      nextCycle();
      cycles++;
      if (lvl_ack) acks++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_code"}, dac_code, DEFCODE);
    checkOutput({tag, "_sleep"}, dac_sleep, 0);
    checkOutput({tag, "_ready"}, dac_ready, 0);
    checkOutput({tag, "_busy"}, swp_busy, 0);
    checkOutput({tag, "_done"}, swp_done, 0);
    checkOutput({tag, "_ack"}, lvl_ack, 0);
  endtask

  // Request held for 1+extra sampling edges; an edge that sees the ack high is not a new request.
  task automatic runLevel(input int code, input int extra);
    int acks;
    bit prev_ack;
    bit exp_ack;
    acks = 0;
    prev_ack = 1'b0;
    lvl_req  = 1'b1;
    lvl_code = CODE_W'(code);
    for (int i = 0; i <= extra; i++) begin
      nextCycle();
      exp_ack = !prev_ack;
      checkOutput("lvl_ack", lvl_ack, exp_ack);
      checkOutput("lvl_code", dac_code, code);
      if (lvl_ack) acks++;
      prev_ack = exp_ack;
    end
    lvl_req = 1'b0;
    nextCycle();
    checkOutput("lvl_ack_drop", lvl_ack, 0);
    checkOutput("lvl_ack_count", acks, (extra / 2) + 1);
    model_code = code;
  endtask

  task automatic runSweep(input int lo, input int hi, input int step, input int hold,
                          input int abort_at, input bit with_lvl, input int lvl_c);
    int codes[$];
    int s, h, v, total, stop;
    bit aborted;
    s = (step == 0) ? 1 : step;
    h = (hold == 0) ? 1 : hold;
    v = lo;
    do begin
      codes.push_back(v);
      v += s;
    end while (v <= hi && v <= 255);
    total   = codes.size() * h;
    aborted = (abort_at >= 0) && (abort_at < total);
    stop    = aborted ? abort_at + 1 : total;

    swp_lo    = CODE_W'(lo);
    swp_hi    = CODE_W'(hi);
    swp_step  = CODE_W'(step);
    swp_hold  = HOLD_W'(hold);
    swp_start = 1'b1;
    if (with_lvl) begin
      lvl_req  = 1'b1;
      lvl_code = CODE_W'(lvl_c);
    end
    nextCycle();
    swp_start = 1'b0;
    for (int c = 0; c <= stop; c++) begin
      if (c > 0) nextCycle();
      checkOutput("swp_code", dac_code, codes[(c < stop ? c : stop - 1) / h]);
      checkOutput("swp_busy", swp_busy, c < stop);
      checkOutput("swp_done", swp_done, (c == total) && !aborted);
      checkOutput("swp_ready", dac_ready, c >= stop);
      if (with_lvl) checkOutput("swp_lvl_wait", lvl_ack, 0);
      swp_abort = (c == abort_at);
    end
    swp_abort  = 1'b0;
    model_code = codes[(stop - 1) / h];
    nextCycle();
    if (with_lvl) begin
      checkOutput("post_swp_ack", lvl_ack, 1);
      checkOutput("post_swp_code", dac_code, lvl_c);
      lvl_req = 1'b0;
      model_code = lvl_c;
      nextCycle();
      checkOutput("post_swp_ack_drop", lvl_ack, 0);
    end else begin
      checkOutput("done_pulse_end", swp_done, 0);
      checkOutput("post_swp_code", dac_code, model_code);
    end
  endtask

  task automatic runSleep(input int dur, input int lvl_c);
    int n, acks;
    sleep_req = 1'b1;
    nextCycle();
    checkOutput("sleep_pin", dac_sleep, 1);
    checkOutput("sleep_ready", dac_ready, 0);
    checkOutput("sleep_code", dac_code, model_code);
    lvl_req  = 1'b1;
    lvl_code = CODE_W'(lvl_c);
    acks = 0;
    for (int i = 0; i < dur; i++) begin
      nextCycle();
      if (lvl_ack || !dac_sleep) acks++;
    end
    checkOutput("sleep_hold", acks, 0);
    sleep_req = 1'b0;
    nextCycle();
    checkOutput("wake_sleep_pin", dac_sleep, 0);
    checkOutput("wake_code", dac_code, model_code);
    waitReady(n, acks);
    checkOutput("sleep_wake_len", n, WAKE);
    checkOutput("sleep_wake_ack", acks, 0);
    nextCycle();
    checkOutput("sleep_lvl_ack", lvl_ack, 1);
    checkOutput("sleep_lvl_code", dac_code, lvl_c);
    lvl_req = 1'b0;
    model_code = lvl_c;
    nextCycle();
  endtask

  task automatic applyStimulus(input int op);
    int abort_at;
    if (op < 4) begin
      runLevel($urandom_range(0, 255), $urandom_range(0, 3));
    end else if (op < 9) begin
      abort_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1;
      runSweep($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 40),
               $urandom_range(0, 3), abort_at, 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    end else begin
      runSleep($urandom_range(1, 6), $urandom_range(0, 255));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int n, acks, k;
    $display("[TB] starting dac_seq_ctrl bench");
    rst = 1'b1;
    repeat (3) nextCycle();
    checkResetValues("reset");

    // Release with a level request and a start pulse already waiting during wake.
    rst       = 1'b0;
    lvl_req   = 1'b1;
    lvl_code  = 8'h40;
    swp_lo    = 8'd5;
    swp_hi    = 8'd9;
    swp_step  = 8'd1;
    swp_hold  = 16'd1;
    swp_start = 1'b1;
    nextCycle();
    swp_start = 1'b0;
    checkOutput("wake_ignores_start", swp_busy, 0);
    checkOutput("wake_code", dac_code, DEFCODE);
    waitReady(n, acks);
    checkOutput("reset_wake_len", n + 1, WAKE);
    checkOutput("reset_wake_ack", acks, 0);
    checkOutput("wake_no_sweep", swp_busy, 0);
    nextCycle();
    checkOutput("wake_lvl_ack", lvl_ack, 1);
    checkOutput("wake_lvl_code", dac_code, 8'h40);
    lvl_req = 1'b0;
    model_code = 8'h40;
    nextCycle();

    runLevel(8'h40, 0);
    runLevel(8'h33, 2);
    runSweep(10, 20, 5, 3, -1, 1'b0, 0);
    runSweep(250, 255, 4, 1, -1, 1'b0, 0);
    runSweep(30, 10, 5, 2, -1, 1'b0, 0);
    runSweep(10, 20, 5, 3, -1, 1'b1, 8'h80);
    runSweep(10, 20, 5, 3, 4, 1'b0, 0);
    runSleep(4, 8'h21);

    // Asynchronous reset in the middle of a sweep.
    swp_lo = 8'd10; swp_hi = 8'd200; swp_step = 8'd1; swp_hold = 16'd2;
    swp_start = 1'b1;
    nextCycle();
    swp_start = 1'b0;
    k = $urandom_range(1, 20);
    repeat (k) nextCycle();
    #2 rst = 1'b1;
    #1;
    checkResetValues("rst_mid_sweep");
    nextCycle();
    rst = 1'b0;
    waitReady(n, acks);
    checkOutput("rst_sweep_wake_len", n, WAKE);
    checkOutput("rst_sweep_discarded", swp_busy, 0);
    model_code = DEFCODE;

    // Asynchronous reset in the middle of wake restarts the full wake time.
    sleep_req = 1'b1;
    nextCycle();
    sleep_req = 1'b0;
    nextCycle();
    k = $urandom_range(10, 90);
    repeat (k) nextCycle();
    #2 rst = 1'b1;
    #1;
    checkResetValues("rst_mid_wake");
    nextCycle();
    rst = 1'b0;
    waitReady(n, acks);
    checkOutput("rst_wake_len", n, WAKE);
    nextCycle();

    for (int i = 0; i < 30; i++) applyStimulus($urandom_range(0, 9));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dac_seq_ctrl.md
# dac_seq_ctrl

Sequencer and arbiter for the 8-bit parallel DAC data bus. It owns the registered code that drives the DAC pins (`dac_da`). It shares the bus between a single-shot level requester and a stepped sweep generator, and it sequences DAC power: sleep, a timed wake, then ready. It sits between the control/config logic and the DAC pin driver, which supplies `dac_clka`, `dac_wra` and `dac_mode`.

## Interface
- `CODE_W`, 8: DAC code width.
- `DEFAULT_CODE`, 178: code driven after reset.
- `WAKE_CYCLES`, 100: cycles from sleep release (or reset) to ready; must be ≥1.
- `HOLD_W`, 16: width of the per-step hold count.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lvl_req`  in  1  level request; held high until `lvl_ack`.
- `lvl_code`  in  CODE_W  code to apply; stable while `lvl_req` is high.
- `lvl_ack`  out  1  one-cycle pulse; `dac_code` already equals `lvl_code`.
- `swp_start`  in  1  one-cycle start pulse; sampled only in IDLE.
- `swp_lo`, `swp_hi`  in  CODE_W  sweep bounds; sampled with `swp_start`.
- `swp_step`  in  CODE_W  increment; 0 is treated as 1.
- `swp_hold`  in  HOLD_W  cycles per code; 0 is treated as 1.
- `swp_abort`  in  1  stops an active sweep.
- `swp_busy`  out  1  high in SWEEP.
- `swp_done`  out  1  one-cycle pulse when a sweep completes normally.
- `sleep_req`  in  1  level; requests DAC power-down.
- `dac_code`  out  CODE_W  registered code to the DAC pin driver.
- `dac_sleep`  out  1  DAC sleep pin.
- `dac_ready`  out  1  high in IDLE.

## Operation
- States: WAKE, IDLE, SWEEP, SLEEP.
- Reset values: state = WAKE, wake counter = 0, `dac_code` = `DEFAULT_CODE`, all other outputs 0.
- WAKE:
  - Counts `WAKE_CYCLES` cycles, then enters IDLE.
  - Requests wait: no ack is issued, and `swp_start` is ignored.
- IDLE: one decision per cycle, in priority order.
  - `swp_abort` has no effect in IDLE.
  - First priority, `swp_start`: latch lo/hi/step/hold, set `dac_code` = lo, enter SWEEP. A pending `lvl_req` stays pending.
  - Second priority, `lvl_req` (ignored in any cycle where `lvl_ack` is high): set `dac_code` = `lvl_code` and pulse `lvl_ack` on the same edge.
  - Third priority, `sleep_req`: enter SLEEP.
- SWEEP:
  - Each code is held for exactly `hold` cycles.
  - Next code = current + step, computed at CODE_W+1 bits.
  - If the next code is greater than hi, or overflows, the sweep ends. `dac_code` keeps the last emitted code, `swp_done` pulses, and the state returns to IDLE.
  - If lo > hi, only lo is emitted, for one hold period.
  - `swp_abort` leaves SWEEP on the next edge: return to IDLE, keep `dac_code`, no `swp_done`.
  - `lvl_req` and `sleep_req` wait until SWEEP ends.
- SLEEP:
  - `dac_sleep` = 1 and `dac_code` is held.
  - When `sleep_req` goes low, enter WAKE with the counter cleared and `dac_sleep` = 0.
- Asynchronous `rst` mid-sweep or mid-wake returns immediately to the reset values. Latched sweep parameters are discarded.

## Timing
- Level write: request sampled at edge E; `dac_code` and `lvl_ack` update at E; `lvl_ack` is high for the cycle after E.
  - Requester drops `lvl_req` in the ack cycle → no second write.
  - `lvl_req` still high one cycle after the ack → treated as a new request.
- Sweep: `swp_start` sampled at edge E0.
  - The first code appears after E0.
  - Code k (k = 0…N−1) is valid for cycles [k·H, (k+1)·H) after E0.
  - `swp_busy` is high for exactly N·H cycles.
  - `swp_done` is high in cycle N·H, the same cycle `swp_busy` is low and `dac_ready` is high.
- Abort sampled at edge A: `swp_busy` is low and `dac_ready` is high in the cycle after A.
- Wake: `dac_ready` rises exactly `WAKE_CYCLES` cycles after reset release or after `sleep_req` falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `dac_pkg`: state encoding, `CODE_W`, `DEFAULT_CODE`.
- Sub-module `dac_sweep_gen`: step/hold counter.
  - Inputs: lo, hi, step, hold, start, abort.
  - Outputs: code, code_valid, last.
- Top level: state machine, arbitration, wake counter, output registers.

## Test plan
- Reset, hold `rst` 3 cycles, release → `dac_code` = 178, `dac_sleep` = 0; `dac_ready` rises exactly 100 cycles later.
- In IDLE, `lvl_req` with `lvl_code` = 0x40 → `dac_code` = 0x40 and a single-cycle `lvl_ack`; a request held two extra cycles gives exactly two acks.
- Sweep lo = 10, hi = 20, step = 5, hold = 3 → 10, 15, 20, each for 3 cycles; `swp_done` 9 cycles after start; `dac_code` stays 20.
- Sweep lo = 250, hi = 255, step = 4, hold = 1 → 250, 254, then done with no wrap; sweep lo = 30, hi = 10 → single code 30.
- `swp_start` and `lvl_req` (0x80) in the same cycle → sweep runs first; `lvl_ack` comes 1 cycle after `swp_done`. Abort at cycle 4 of a hold = 3 sweep → code 15 held, no `swp_done`.
- `sleep_req` high in IDLE → `dac_sleep` = 1 next cycle; a `lvl_req` is not acked until `sleep_req` falls plus 100 wake cycles. `rst` mid-sweep → immediate default values, `swp_busy` = 0.
